// File: rtl/mof_screen_pkg.sv
// Shared types and fp32 helpers for the MOF screening controller.
package mof_screen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_COLLECT,
    ST_SETTLE,
    ST_EVAL,
    ST_DONE
  } state_t;

  localparam logic [31:0] FP32_HALF = 32'h3F00_0000;
  localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;

  // Maps fp32 bit patterns onto unsigned keys whose order is the fp32 total order.
  function automatic logic [31:0] fp32_key(input logic [31:0] x);
    return x[31] ? ~x : (x ^ 32'h8000_0000);
  endfunction

endpackage

// File: rtl/mof_screening_controller_if.sv
// VQE request/measurement handshake between the screening controller and the VQE processor.
interface mof_screening_controller_if;
  logic        hamiltonian_ready;
  logic        energy_measurement_ready;
  logic [31:0] ground_state_energy;
  logic [31:0] catalyst_score;
  logic [31:0] stability_prediction;

  modport master (
    output hamiltonian_ready,
    input  energy_measurement_ready,
    input  ground_state_energy,
    input  catalyst_score,
    input  stability_prediction
  );

  modport slave (
    input  hamiltonian_ready,
    output energy_measurement_ready,
    output ground_state_energy,
    output catalyst_score,
    output stability_prediction
  );
endinterface

// File: rtl/mof_run_accumulator.sv
// Per-run collector: pulse count, minimum energy, last score/stability and the pulse watchdog.
module mof_run_accumulator
  import mof_screen_pkg::*;
#(
  parameter int MEAS_PER_RUN   = 10,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        active,
  input  logic        pulse,
  input  logic [31:0] energy,
  input  logic [31:0] score,
  input  logic [31:0] stability,
  output logic [31:0] min_energy,
  output logic [31:0] last_score,
  output logic [31:0] last_stability,
  output logic        timed_out,
  output logic        last_pulse,
  output logic        timeout_hit
);

  localparam int MEAS_W = $clog2(MEAS_PER_RUN + 1);
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [MEAS_W-1:0] MEAS_LAST = MEAS_W'(MEAS_PER_RUN - 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [MEAS_W-1:0] meas_cnt;
  logic [WAIT_W-1:0] wait_cnt;

  assign last_pulse  = active && pulse && (meas_cnt == MEAS_LAST);
  // A pulse on the terminal-count cycle wins over the timeout.
  assign timeout_hit = active && !pulse && (wait_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meas_cnt       <= '0;
      wait_cnt       <= '0;
      min_energy     <= '0;
      last_score     <= '0;
      last_stability <= '0;
      timed_out      <= 1'b0;
    end else if (clear) begin
      meas_cnt       <= '0;
      wait_cnt       <= WAIT_LOAD;
      min_energy     <= '0;
      last_score     <= '0;
      last_stability <= '0;
      timed_out      <= 1'b0;
    end else if (active && pulse) begin
      meas_cnt       <= meas_cnt + 1'b1;
      wait_cnt       <= WAIT_LOAD;
      last_score     <= score;
      last_stability <= stability;
      if (meas_cnt == '0 || fp32_key(energy) < fp32_key(min_energy))
        min_energy <= energy;
    end else if (timeout_hit) begin
      timed_out <= 1'b1;
    end else if (active) begin
      wait_cnt <= wait_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/mof_screening_controller.sv
// Screens NUM_MATERIALS candidates through the VQE processor and reports the best eligible one.
// Optional build macro MOF_SCREEN_STAB_FILTER_EN adds the STAB_MIN stability test to eligibility.
//   state   | meaning
//   IDLE    | waiting for start
//   ISSUE   | hamiltonian_ready pulse for the current run
//   COLLECT | gathering measurement pulses, watchdog running
//   SETTLE  | quiet gap after the run, pulses ignored
//   EVAL    | compare run against best, advance run index
//   DONE    | one-cycle done pulse
module mof_screening_controller
  import mof_screen_pkg::*;
#(
  parameter int          NUM_MATERIALS  = 6,
  parameter int          MEAS_PER_RUN   = 10,
  parameter int          SETTLE_CYCLES  = 3,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] STAB_MIN       = FP32_HALF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  mof_screening_controller_if.master vqe,
  output logic                       busy,
  output logic                       done,
  output logic                       best_valid,
  output logic [2:0]                 best_material,
  output logic [31:0]                best_energy,
  output logic [31:0]                best_score,
  output logic                       timeout_err
);

  localparam int RUN_W    = (NUM_MATERIALS > 1) ? $clog2(NUM_MATERIALS) : 1;
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [RUN_W-1:0]    RUN_LAST    = RUN_W'(NUM_MATERIALS - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

  state_t              state;
  logic [RUN_W-1:0]    run_idx;
  logic [SETTLE_W-1:0] settle_cnt;

  logic [31:0] acc_energy;
  logic [31:0] acc_score;
  logic [31:0] acc_stability;
  logic        acc_timed_out;
  logic        acc_last_pulse;
  logic        acc_timeout_hit;
  logic        stab_ok;
  logic        eligible;
  logic        better;

  mof_run_accumulator #(
    .MEAS_PER_RUN   (MEAS_PER_RUN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_acc (
    .clk            (clk),
    .reset          (reset),
    .clear          (state == ST_ISSUE),
    .active         (state == ST_COLLECT),
    .pulse          (vqe.energy_measurement_ready),
    .energy         (vqe.ground_state_energy),
    .score          (vqe.catalyst_score),
    .stability      (vqe.stability_prediction),
    .min_energy     (acc_energy),
    .last_score     (acc_score),
    .last_stability (acc_stability),
    .timed_out      (acc_timed_out),
    .last_pulse     (acc_last_pulse),
    .timeout_hit    (acc_timeout_hit)
  );

`ifdef MOF_SCREEN_STAB_FILTER_EN
  assign stab_ok = fp32_key(acc_stability) >= fp32_key(STAB_MIN);
`else
  logic unused_stab;
  assign stab_ok     = 1'b1;
  assign unused_stab = ^{acc_stability, STAB_MIN};
`endif

  always_comb begin
    eligible = !acc_timed_out && stab_ok;
    better   = !best_valid
            || (fp32_key(acc_score) > fp32_key(best_score))
            || ((acc_score == best_score) && (fp32_key(acc_energy) < fp32_key(best_energy)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                 <= ST_IDLE;
      run_idx               <= '0;
      settle_cnt            <= '0;
      vqe.hamiltonian_ready <= 1'b0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      best_valid            <= 1'b0;
      best_material         <= '0;
      best_energy           <= '0;
      best_score            <= '0;
      timeout_err           <= 1'b0;
    end else begin
      vqe.hamiltonian_ready <= 1'b0;
      done                  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state                 <= ST_ISSUE;
            vqe.hamiltonian_ready <= 1'b1;
            busy                  <= 1'b1;
            run_idx               <= '0;
            best_valid            <= 1'b0;
            best_material         <= '0;
            best_energy           <= '0;
            best_score            <= '0;
            timeout_err           <= 1'b0;
          end
        end
        ST_ISSUE: state <= ST_COLLECT;
        ST_COLLECT: begin
          if (acc_last_pulse) begin
            state      <= ST_SETTLE;
            settle_cnt <= SETTLE_LOAD;
          end else if (acc_timeout_hit) begin
            state       <= ST_SETTLE;
            settle_cnt  <= SETTLE_LOAD;
            timeout_err <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) state <= ST_EVAL;
          else                  settle_cnt <= settle_cnt - 1'b1;
        end
        ST_EVAL: begin
          if (eligible && better) begin
            best_valid    <= 1'b1;
            best_material <= 3'(run_idx);
            best_energy   <= acc_energy;
            best_score    <= acc_score;
          end
          if (run_idx == RUN_LAST) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            run_idx               <= run_idx + 1'b1;
            state                 <= ST_ISSUE;
            vqe.hamiltonian_ready <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mof_screening_controller.sv
// Directed bench for mof_screening_controller with an in-line VQE pulse model.
module tb_mof_screening_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic        best_valid;
  logic [2:0]  best_material;
  logic [31:0] best_energy;
  logic [31:0] best_score;
  logic        timeout_err;

  int tests = 0;
  int fails = 0;
  int hr_cnt = 0;
  int done_cnt = 0;

  logic [31:0] sc [6];
  logic [31:0] st [6];
  logic [31:0] en [6][10];
  bit          silent [6];

`ifdef MOF_SCREEN_STAB_FILTER_EN
  localparam logic [31:0] MAIN_MAT   = 32'd1;
  localparam logic [31:0] MAIN_SCORE = 32'h3F40_0000;
`else
  localparam logic [31:0] MAIN_MAT   = 32'd2;
  localparam logic [31:0] MAIN_SCORE = 32'h3F60_0000;
`endif

  mof_screening_controller_if vqe_if ();

  mof_screening_controller dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .vqe           (vqe_if),
    .busy          (busy),
    .done          (done),
    .best_valid    (best_valid),
    .best_material (best_material),
    .best_energy   (best_energy),
    .best_score    (best_score),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (vqe_if.hamiltonian_ready) hr_cnt++;
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag, input logic valid, input logic [31:0] mat,
                              input logic [31:0] energy, input logic [31:0] score, input logic terr);
    check1({tag, "_valid"}, best_valid, valid);
    check({tag, "_material"}, 32'(best_material), mat);
    check({tag, "_energy"}, best_energy, energy);
    check({tag, "_score"}, best_score, score);
    check1({tag, "_timeout_err"}, timeout_err, terr);
  endtask

  // Mg, Fe, Co, Ni, Cu, Zn; Co scores highest but is unstable.
  task automatic load_main();
    sc = '{32'h3E80_0000, 32'h3F40_0000, 32'h3F60_0000, 32'h3F00_0000, 32'h3E00_0000, 32'h3F20_0000};
    st = '{32'h3F80_0000, 32'h3F4C_CCCD, 32'h3E80_0000, 32'h3F00_0000, 32'h3F80_0000, 32'h3EFF_FFFF};
    for (int r = 0; r < 6; r++) begin
      silent[r] = 1'b0;
      for (int k = 0; k < 10; k++) en[r][k] = 32'hC0A0_0000 + 32'(k);
    end
  endtask

  task automatic drive_pulse(input logic [31:0] e, input logic [31:0] s, input logic [31:0] p);
    vqe_if.energy_measurement_ready = 1'b1;
    vqe_if.ground_state_energy      = e;
    vqe_if.catalyst_score           = s;
    vqe_if.stability_prediction     = p;
  endtask

  // Runs one screen; abort_run >= 0 stops after 4 pulses of that run.
  task automatic do_screen(input int abort_run, input bit poke_start);
    bit seen;
    int lat;
    int npulse;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check1("hr_after_start", vqe_if.hamiltonian_ready, 1'b1);
    check1("busy_after_start", busy, 1'b1);
    for (int r = 0; r < 6; r++) begin
      if (r > 0) begin
        seen = 1'b0;
        for (int t = 0; t < 300 && !seen; t++) begin
          @(negedge clk);
          seen = vqe_if.hamiltonian_ready;
        end
        if (!seen) begin
          check1("hr_wait", 1'b0, 1'b1);
          return;
        end
      end
      @(negedge clk);
      if (r == 0) check1("hr_one_cycle", vqe_if.hamiltonian_ready, 1'b0);
      if (poke_start && r == 2) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      npulse = (r == abort_run) ? 4 : 10;
      if (!silent[r]) begin
        for (int k = 0; k < npulse; k++) begin
          if (k == 9) drive_pulse(en[r][k], sc[r], st[r]);
          else        drive_pulse(en[r][k], 32'h7F00_0000, 32'h0000_0000);
          @(negedge clk);
          if (k == 9) drive_pulse(32'hFF80_0000, 32'h7F00_0000, 32'h3F80_0000);
          else        vqe_if.energy_measurement_ready = 1'b0;
          @(negedge clk);
          vqe_if.energy_measurement_ready = 1'b0;
        end
      end
      if (r == abort_run) return;
    end
    lat = 2;
    seen = done;
    while (!seen && lat < 60) begin
      @(negedge clk);
      lat++;
      seen = done;
    end
    check("done_latency", 32'(lat), 32'd5);
    @(negedge clk);
    check1("done_one_cycle", done, 1'b0);
    check1("busy_after_done", busy, 1'b0);
  endtask

  initial begin
    int h0;
    int d0;
    reset = 1'b1;
    start = 1'b0;
    vqe_if.energy_measurement_ready = 1'b0;
    vqe_if.ground_state_energy      = '0;
    vqe_if.catalyst_score           = '0;
    vqe_if.stability_prediction     = '0;
    repeat (2) @(negedge clk);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_hr", vqe_if.hamiltonian_ready, 1'b0);
    check_result("rst", 1'b0, 32'd0, 32'h0, 32'h0, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    load_main();
    h0 = hr_cnt;
    d0 = done_cnt;
    do_screen(-1, 1'b1);
    repeat (4) @(negedge clk);
    check("main_hr_count", 32'(hr_cnt - h0), 32'd6);
    check("main_done_count", 32'(done_cnt - d0), 32'd1);
    check1("main_idle_busy", busy, 1'b0);
    check_result("main", 1'b1, MAIN_MAT, 32'hC0A0_0009, MAIN_SCORE, 1'b0);

    load_main();
    silent[2] = 1'b1;
    do_screen(-1, 1'b0);
    check_result("tmo", 1'b1, 32'd1, 32'hC0A0_0009, 32'h3F40_0000, 1'b1);

    load_main();
    for (int r = 0; r < 6; r++) begin
      st[r] = 32'h3F80_0000;
      sc[r] = (r < 2) ? 32'h3F40_0000 : 32'h3E80_0000;
    end
    for (int k = 5; k < 10; k++) en[0][k] = 32'hC0A0_0004;
    do_screen(-1, 1'b0);
    check_result("tie", 1'b1, 32'd1, 32'hC0A0_0009, 32'h3F40_0000, 1'b0);

    for (int r = 0; r < 6; r++) begin
      sc[r] = 32'h3F40_0000;
      st[r] = 32'h3F80_0000;
      for (int k = 0; k < 10; k++) en[r][k] = (k == 0) ? 32'hC0A0_0000 : 32'h3F80_0000;
    end
    do_screen(-1, 1'b0);
    check_result("ident", 1'b1, 32'd0, 32'hC0A0_0000, 32'h3F40_0000, 1'b0);

    load_main();
    silent[1] = 1'b1;
    do_screen(3, 1'b0);
    check1("pre_rst_busy", busy, 1'b1);
    check1("pre_rst_valid", best_valid, 1'b1);
    check1("pre_rst_terr", timeout_err, 1'b1);
    #2 reset = 1'b1;
    #1;
    check1("mid_rst_busy", busy, 1'b0);
    check1("mid_rst_done", done, 1'b0);
    check1("mid_rst_hr", vqe_if.hamiltonian_ready, 1'b0);
    check_result("mid_rst", 1'b0, 32'd0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    load_main();
    h0 = hr_cnt;
    do_screen(-1, 1'b0);
    check("restart_hr_count", 32'(hr_cnt - h0), 32'd6);
    check_result("restart", 1'b1, MAIN_MAT, 32'hC0A0_0009, MAIN_SCORE, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
